// File: rtl/key_expand_iter.sv
`default_nettype none
// ============================================================================
//  Module   : sbox
//  Purpose  : AES forward S-box, byte in / byte out, purely combinational.
//             Computed as the GF(2^8) multiplicative inverse (x^254) followed
//             by the AES affine transform. This avoids a 256-entry table.
//  Ports    : i_in   [7:0]  input byte
//             o_out  [7:0]  substituted byte
//  Revision : 1.0  initial release
// ============================================================================
module sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^(2+4+...+128); maps 0 to 0, which is what the S-box wants
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] w_inv;

    always_comb begin
        w_inv = ginv(i_in);
        o_out = w_inv
              ^ {w_inv[6:0], w_inv[7]}
              ^ {w_inv[5:0], w_inv[7:6]}
              ^ {w_inv[4:0], w_inv[7:5]}
              ^ {w_inv[3:0], w_inv[7:4]}
              ^ 8'h63;
    end

endmodule

// ============================================================================
//  Module   : key_expand_iter
//  Purpose  : Iterative AES key schedule for 128/192/256-bit keys. Generates
//             one 32-bit schedule word per cycle and emits one 128-bit round
//             key (with its round number) per valid/ready handshake.
//  Ports    : clk        rising-edge clock
//             reset      asynchronous active-low reset
//             start      request expansion (sampled only when idle)
//             keyLen     0=128, 1=192, 2=256, 3=illegal
//             key        cipher key, left-aligned (w0 = key[255:224])
//             clear      synchronous abort
//             key_ready  downstream accepts outKey
//             key_valid  outKey/rnum_out/last valid
//             outKey     round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
//             rnum_out   round index r
//             last       final round key flag
//             busy       expansion in progress
//             err        one-cycle pulse on start with keyLen==3
//  Revision : 1.0  initial release
// ============================================================================
module key_expand_iter #(
    parameter int WORD    = 32,
    parameter int KEY_MAX = 256,
    parameter int NK_MAX  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           keyLen,
    input  logic [KEY_MAX-1:0]   key,
    input  logic                 clear,
    input  logic                 key_ready,
    output logic                 key_valid,
    output logic [4*WORD-1:0]    outKey,
    output logic [3:0]           rnum_out,
    output logic                 last,
    output logic                 busy,
    output logic                 err
);

    localparam int IDXW = $clog2(NK_MAX);
    localparam int JW   = 6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [WORD-1:0]     r_keyw [NK_MAX];
    logic [WORD-1:0]     r_win  [NK_MAX];   // slot0 = newest word
    logic [3*WORD-1:0]   r_col;             // first three words of current round key
    logic [IDXW-1:0]     r_nkm1;            // Nk-1
    logic [3:0]          r_nr;
    logic [JW-1:0]       r_last_j;          // index of final word, 4*Nr+3
    logic [JW-1:0]       r_j;
    logic [IDXW-1:0]     r_jmod;            // j % Nk, kept as a wrapping counter
    logic [7:0]          r_rcon;
    logic                r_gen;             // words still to be generated
    logic                r_key_valid;
    logic [4*WORD-1:0]   r_out_key;
    logic [3:0]          r_rnum;
    logic                r_last;
    logic                r_busy;
    logic                r_err;

    logic [WORD-1:0]     w_prev;
    logic [WORD-1:0]     w_old;
    logic [WORD-1:0]     w_sub_in;
    logic [WORD-1:0]     w_sub;
    logic [WORD-1:0]     w_t;
    logic [WORD-1:0]     w_new;
    logic                w_key_phase;
    logic                w_rcon_step;
    logic                w_sub_only;
    logic                w_adv;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_sbox
            sbox u_sbox (
                .i_in  (w_sub_in[8*b +: 8]),
                .o_out (w_sub[8*b +: 8])
            );
        end
    endgenerate

    always_comb begin
        w_prev      = r_win[0];
        w_old       = r_win[r_nkm1];
        w_key_phase = (r_j <= {{(JW-IDXW){1'b0}}, r_nkm1});
        w_rcon_step = !w_key_phase && (r_jmod == '0);
        // Extra SubWord in the middle of each 8-word block, 256-bit keys only
        w_sub_only  = !w_key_phase && (r_nkm1 == IDXW'(NK_MAX-1)) && (r_jmod == IDXW'(4));
        w_sub_in    = w_sub_only ? w_prev : {w_prev[23:0], w_prev[31:24]};

        if (w_rcon_step)
            w_t = w_sub ^ {r_rcon, 24'h000000};
        else if (w_sub_only)
            w_t = w_sub;
        else
            w_t = w_prev;

        w_new = w_key_phase ? r_keyw[r_j[IDXW-1:0]] : (w_old ^ w_t);

        // Generation stalls while a presented key is being held back
        w_adv = (r_state == S_RUN) && r_gen && !(r_key_valid && !key_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < NK_MAX; i++) begin
                r_keyw[i] <= '0;
                r_win[i]  <= '0;
            end
            r_col       <= '0;
            r_nkm1      <= '0;
            r_nr        <= '0;
            r_last_j    <= '0;
            r_j         <= '0;
            r_jmod      <= '0;
            r_rcon      <= '0;
            r_gen       <= 1'b0;
            r_key_valid <= 1'b0;
            r_out_key   <= '0;
            r_rnum      <= '0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_gen       <= 1'b0;
            r_key_valid <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_err <= start && (keyLen == 2'd3);
                    if (start && (keyLen != 2'd3)) begin
                        for (int i = 0; i < NK_MAX; i++)
                            r_keyw[i] <= key[KEY_MAX-1-WORD*i -: WORD];
                        case (keyLen)
                            2'd0: begin
                                r_nkm1   <= IDXW'(3);
                                r_nr     <= 4'd10;
                                r_last_j <= JW'(43);
                            end
                            2'd1: begin
                                r_nkm1   <= IDXW'(5);
                                r_nr     <= 4'd12;
                                r_last_j <= JW'(51);
                            end
                            default: begin
                                r_nkm1   <= IDXW'(7);
                                r_nr     <= 4'd14;
                                r_last_j <= JW'(59);
                            end
                        endcase
                        r_j     <= '0;
                        r_jmod  <= '0;
                        r_rcon  <= 8'h01;
                        r_gen   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_err <= 1'b0;

                    if (r_key_valid && key_ready) begin
                        r_key_valid <= 1'b0;
                        if (r_last) begin
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end

                    if (w_adv) begin
                        r_win[0] <= w_new;
                        for (int i = 1; i < NK_MAX; i++)
                            r_win[i] <= r_win[i-1];
                        r_j    <= r_j + JW'(1);
                        r_jmod <= (r_jmod == r_nkm1) ? '0 : r_jmod + IDXW'(1);
                        if (w_rcon_step)
                            r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                        if (r_j[1:0] == 2'd3) begin
                            // Reload overrides the retire above in the same edge
                            r_out_key   <= {r_col, w_new};
                            r_rnum      <= r_j[5:2];
                            r_key_valid <= 1'b1;
                            r_last      <= (r_j[5:2] == r_nr);
                        end else begin
                            r_col <= {r_col[2*WORD-1:0], w_new};
                        end
                        if (r_j == r_last_j)
                            r_gen <= 1'b0;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign key_valid = r_key_valid;
    assign outKey    = r_out_key;
    assign rnum_out  = r_rnum;
    assign last      = r_last;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_key_expand_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_expand_iter
//  Purpose  : Self-checking bench for key_expand_iter. Expected round keys
//             are queued at stimulus time; a negedge monitor pops and
//             compares on every handshake and checks hold stability.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_expand_iter;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   keyLen;
    logic [255:0] key;
    logic         clear;
    logic         key_ready;
    logic         key_valid;
    logic [127:0] outKey;
    logic [3:0]   rnum_out;
    logic         last;
    logic         busy;
    logic         err;

    key_expand_iter #(.WORD(32), .KEY_MAX(256), .NK_MAX(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .keyLen    (keyLen),
        .key       (key),
        .clear     (clear),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .outKey    (outKey),
        .rnum_out  (rnum_out),
        .last      (last),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   rnum;
        logic         lst;
        logic         known;
        logic [127:0] k;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;
    int           last_hs = -1;
    logic         gap_chk = 1'b0;
    logic         mon_en  = 1'b1;
    logic         stall_prev = 1'b0;
    logic [127:0] stall_key;
    logic [3:0]   stall_rnum;
    logic [127:0] k128 [0:10];

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hdeadbeefcafef00d};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: stability while held, scoreboard pop on handshake
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_prev) begin
                chk("hold_valid", {127'b0, key_valid}, 128'd1);
                if (key_valid) begin
                    chk("hold_key", outKey, stall_key);
                    chk("hold_rnum", {124'b0, rnum_out}, {124'b0, stall_rnum});
                end
            end
            if (key_valid && key_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_key: got round %0d, expected no key", rnum_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rnum", {124'b0, rnum_out}, {124'b0, e.rnum});
                    chk("last", {127'b0, last}, {127'b0, e.lst});
                    if (e.known) chk("round_key", outKey, e.k);
                    if (gap_chk && last_hs >= 0)
                        chk("key_gap", 128'(cyc - last_hs), 128'd4);
                    last_hs = cyc;
                end
                stall_prev = 1'b0;
            end else if (key_valid) begin
                stall_prev = 1'b1;
                stall_key  = outKey;
                stall_rnum = rnum_out;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Queue expectations for rounds 0..upto of a key length
    task automatic push_seq(input int len, input int upto);
        int   nr;
        exp_t e;
        nr = (len == 0) ? 10 : (len == 1) ? 12 : 14;
        for (int r = 0; r <= nr && r <= upto; r++) begin
            e.rnum  = 4'(r);
            e.lst   = (r == nr);
            e.known = 1'b0;
            e.k     = '0;
            if (len == 0) begin
                e.known = 1'b1;
                e.k     = k128[r];
            end else if (len == 1) begin
                if (r == 0)  begin e.known = 1'b1; e.k = 128'h8e73b0f7da0e6452c810f32b809079e5; end
                if (r == 1)  begin e.known = 1'b1; e.k = 128'h62f8ead2522c6b7bfe0c91f72402f5a5; end
                if (r == 12) begin e.known = 1'b1; e.k = 128'he98ba06f448c773c8ecc720401002202; end
            end else begin
                if (r == 0)  begin e.known = 1'b1; e.k = 128'h603deb1015ca71be2b73aef0857d7781; end
                if (r == 1)  begin e.known = 1'b1; e.k = 128'h1f352c073b6108d72d9810a30914dff4; end
                if (r == 2)  begin e.known = 1'b1; e.k = 128'h9ba354118e6925afa51a8b5f2067fcde; end
                if (r == 3)  begin e.known = 1'b1; e.k = 128'ha8b09c1a93d194cdbe49846eb75d5b9a; end
                if (r == 14) begin e.known = 1'b1; e.k = 128'hfe4890d1e6188d0b046df344706c631e; end
            end
            q.push_back(e);
        end
    endtask

    // Returns one time unit after the accepting edge E0
    task automatic do_start(input logic [1:0] len, input logic [255:0] k);
        @(posedge clk); #1;
        keyLen  = len;
        key     = k;
        start   = 1'b1;
        last_hs = -1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_busy_done"}, {127'b0, busy}, 128'd0);
        chk({nm, "_all_keys"}, 128'(q.size()), 128'd0);
        chk({nm, "_valid_after"}, {127'b0, key_valid}, 128'd0);
        chk({nm, "_last_after"}, {127'b0, last}, 128'd0);
        q.delete();
    endtask

    task automatic abort_at_r5(input logic use_reset);
        gap_chk = 1'b1;
        push_seq(0, 4);
        do_start(2'd0, KEY128);
        repeat (24) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("r5_valid", {127'b0, key_valid}, 128'd1);
        chk("r5_rnum", {124'b0, rnum_out}, 128'd5);
        chk("r0_r4_seen", 128'(q.size()), 128'd0);
        if (use_reset) begin
            reset = 1'b0;
            #1;
            chk("rst_outkey", outKey, 128'd0);
            chk("rst_rnum", {124'b0, rnum_out}, 128'd0);
            @(posedge clk); #1;
            reset = 1'b1;
        end else begin
            clear = 1'b1;
            @(posedge clk); #1;
            clear = 1'b0;
            chk("clr_err", {127'b0, err}, 128'd0);
        end
        chk("abort_valid", {127'b0, key_valid}, 128'd0);
        chk("abort_busy", {127'b0, busy}, 128'd0);
        chk("abort_last", {127'b0, last}, 128'd0);
        q.delete();
        stall_prev = 1'b0;
        mon_en = 1'b1;
        push_seq(1, 15);
        do_start(2'd1, KEY192);
        wait_done(use_reset ? "restart_rst" : "restart_clr");
    endtask

    initial begin
        k128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        k128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        k128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        k128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        k128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        k128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        k128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        k128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        k128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        k128[9]  = 128'hac7766f319fadc2128d12941575c006e;
        k128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset = 1'b0; start = 1'b0; keyLen = 2'd0; key = '0;
        clear = 1'b0; key_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {127'b0, key_valid}, 128'd0);
        chk("reset_busy", {127'b0, busy}, 128'd0);
        chk("reset_err", {127'b0, err}, 128'd0);
        chk("reset_outkey", outKey, 128'd0);
        reset = 1'b1;

        // AES-128, continuous ready
        gap_chk = 1'b1;
        push_seq(0, 15);
        do_start(2'd0, KEY128);
        chk("busy_after_start", {127'b0, busy}, 128'd1);
        wait_done("aes128");

        // AES-192 and AES-256
        push_seq(1, 15);
        do_start(2'd1, KEY192);
        wait_done("aes192");
        push_seq(2, 15);
        do_start(2'd2, KEY256);
        wait_done("aes256");

        // AES-128 with ready held low for 7 cycles while r3 is presented
        gap_chk = 1'b0;
        push_seq(0, 15);
        do_start(2'd0, KEY128);
        repeat (16) @(posedge clk);
        #1;
        key_ready = 1'b0;
        chk("stall_r3_rnum", {124'b0, rnum_out}, 128'd3);
        repeat (7) @(posedge clk);
        #1;
        chk("stall_busy", {127'b0, busy}, 128'd1);
        key_ready = 1'b1;
        wait_done("stall");

        // Illegal key length
        do_start(2'd3, KEY128);
        chk("err_pulse", {127'b0, err}, 128'd1);
        chk("err_busy", {127'b0, busy}, 128'd0);
        chk("err_valid", {127'b0, key_valid}, 128'd0);
        @(posedge clk); #1;
        chk("err_one_cycle", {127'b0, err}, 128'd0);

        // start and key changes during RUN are ignored
        gap_chk = 1'b1;
        push_seq(0, 15);
        do_start(2'd0, KEY128);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; keyLen = 2'd1; key = KEY256;
        @(posedge clk); #1;
        keyLen = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("run_start_no_err", {127'b0, err}, 128'd0);
        wait_done("start_in_run");

        // Abort by clear, then by reset, each followed by a 192-bit restart
        abort_at_r5(1'b0);
        abort_at_r5(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
